// File: rtl/seg4x7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg4x7_pkg
// Description : Shared definitions for the 4-digit 7-segment display blocks.
//               Segment bit positions within the {dp,g,f,e,d,c,b,a} byte and
//               the single hex <-> segment-pattern table used by both the
//               display encoders and the read-back monitor.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seg4x7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Nibble -> lit-segment pattern (bits g..a, 1 = lit).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Pattern -> {ok, nibble}; unknown patterns (including blank) give 5'b0.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'b0;
        for (int k = 0; k < 16; k++) begin
            if (hex_to_seg(4'(k)) == pat) begin
                res = {1'b1, 4'(k)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg4x7_sync.sv
`default_nettype none
// ============================================================================
// Module      : seg4x7_sync
// Description : Two-flop synchroniser for asynchronous display lines.
// Ports       : clk   - system clock
//               rst_n - synchronous reset, active low (clears both stages)
//               d     - asynchronous input bus
//               q     - synchronised output bus
// Revision    : 1.0 - initial release
// ============================================================================
module seg4x7_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/seg4x7_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seg4x7_monitor
// Description : Snoops a multiplexed 4-digit 7-segment display, captures each
//               digit once its lines have been stable for SETTLE cycles,
//               decodes the patterns and publishes coherent 4-digit frames.
// Ports       : clk, rst_n (sync, active low)
//               digit_sel[3:0]  digit enables (bit0 = leftmost)
//               seg[7:0]        {dp,g,f,e,d,c,b,a}
//               raw[31:0]       lit-normalised segment bytes, byte i = digit i
//               hex[15:0]       decoded nibble per digit
//               hex_ok[3:0]     digit pattern matched the hex table
//               dp[3:0]         decimal point per digit
//               frame_valid     one-cycle pulse when the frame outputs update
//               stalled         no capture for 2**TO_W-1 cycles
// Revision    : 1.0 - initial release
// ============================================================================
module seg4x7_monitor
    import seg4x7_pkg::*;
#(
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int SETTLE         = 16,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digit_sel,
    input  logic [7:0]  seg,
    output logic [31:0] raw,
    output logic [15:0] hex,
    output logic [3:0]  hex_ok,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        stalled
);

    localparam int            CNT_W  = $clog2(SETTLE + 1);
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    logic [3:0]       w_sel_s;
    logic [7:0]       w_seg_s;
    logic [3:0]       w_sel_n;
    logic [7:0]       w_seg_n;
    logic             w_onehot;
    logic             w_retarget;
    logic             w_capture;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_cur_sel, w_cur_sel_nxt;
    logic [7:0]       r_cur_seg, w_cur_seg_nxt;

    logic [7:0]       r_shadow [4];
    logic [3:0]       r_mask;
    logic [4:0]       w_dec [4];
    logic [TO_W-1:0]  r_to_cnt;

    logic [31:0]      r_raw;
    logic [15:0]      r_hex;
    logic [3:0]       r_hex_ok;
    logic [3:0]       r_dp;
    logic             r_fv;

    seg4x7_sync #(.WIDTH(4)) u_sync_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (digit_sel),
        .q     (w_sel_s)
    );

    seg4x7_sync #(.WIDTH(8)) u_sync_seg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (seg),
        .q     (w_seg_s)
    );

    assign w_sel_n  = SEL_ACTIVE_LOW ? ~w_sel_s : w_sel_s;
    assign w_seg_n  = SEG_ACTIVE_LOW ? ~w_seg_s : w_seg_s;
    assign w_onehot = (w_sel_n != 4'd0) && ((w_sel_n & (w_sel_n - 4'd1)) == 4'd0);

    // IDLE re-evaluates every cycle, SETTLE restarts on any line change,
    // HOLD only reacts to a new digit select (segment flicker is ignored).
    always_comb begin
        w_retarget = 1'b0;
        case (r_state)
            ST_IDLE:   w_retarget = 1'b1;
            ST_SETTLE: w_retarget = (w_sel_n != r_cur_sel) || (w_seg_n != r_cur_seg);
            ST_HOLD:   w_retarget = (w_sel_n != r_cur_sel);
            default:   w_retarget = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_sel_nxt = r_cur_sel;
        w_cur_seg_nxt = r_cur_seg;
        w_capture     = 1'b0;
        if (w_retarget) begin
            w_cur_sel_nxt = w_sel_n;
            w_cur_seg_nxt = w_seg_n;
            if (w_onehot) begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = CNT_W'(1);
            end else begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        end else if (r_state == ST_SETTLE) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(SETTLE - 1)) begin
                w_capture   = 1'b1;
                w_state_nxt = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cur_sel <= '0;
            r_cur_seg <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_sel <= w_cur_sel_nxt;
            r_cur_seg <= w_cur_seg_nxt;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_dec
            assign w_dec[i] = seg_to_hex(r_shadow[i][SEG_G:SEG_A]);
        end
    endgenerate

    // Shadow capture, frame assembly and activity timeout. When a frame is
    // published the mask is cleared, except for a capture landing in the
    // same cycle, which seeds the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
            r_mask   <= '0;
            r_to_cnt <= '0;
            r_raw    <= '0;
            r_hex    <= '0;
            r_hex_ok <= '0;
            r_dp     <= '0;
            r_fv     <= 1'b0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (r_cur_sel[i]) begin
                        r_shadow[i] <= r_cur_seg;
                    end
                end
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (r_mask == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    r_raw[8*i +: 8]  <= r_shadow[i];
                    r_hex[4*i +: 4]  <= w_dec[i][3:0];
                    r_hex_ok[i]      <= w_dec[i][4];
                    r_dp[i]          <= r_shadow[i][SEG_DP];
                end
                r_fv   <= 1'b1;
                r_mask <= w_capture ? r_cur_sel : 4'd0;
            end else begin
                r_fv   <= 1'b0;
                r_mask <= r_mask | (w_capture ? r_cur_sel : 4'd0);
            end
        end
    end

    assign raw         = r_raw;
    assign hex         = r_hex;
    assign hex_ok      = r_hex_ok;
    assign dp          = r_dp;
    assign frame_valid = r_fv;
    assign stalled     = (r_to_cnt == TO_MAX);

endmodule
`default_nettype wire
